// File: rtl/alu_exec_stage.sv
// Execute stage around an external combinational ALU: issue register, output register, status flags.
// Optional condition evaluation is compiled in when ALU_COND_EXEC_EN is defined.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_srca,
  input  logic [WIDTH-1:0] in_srcb,
  input  logic [1:0]       in_op,
  input  logic [3:0]       in_cond,
  input  logic             in_setf,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_exec,
  output logic [3:0]       status
);

  logic             r_iss_v;
  logic [WIDTH-1:0] r_iss_a;
  logic [WIDTH-1:0] r_iss_b;
  logic [1:0]       r_iss_op;
  logic             r_iss_setf;

  logic             r_out_v;
  logic [WIDTH-1:0] r_out_result;
  logic [3:0]       r_out_flags;
  logic             r_out_exec;
  logic [3:0]       r_status;

  logic w_adv;
  logic w_accept;
  logic w_pass;

  assign w_adv    = r_iss_v && (!r_out_v || out_ready);
  assign in_ready = rst_n && (!r_iss_v || w_adv);
  assign w_accept = in_valid && in_ready;

`ifdef ALU_COND_EXEC_EN
  logic [3:0] r_iss_cond;
  logic       w_c, w_v, w_n, w_z;

  assign {w_c, w_v, w_n, w_z} = r_status;

  // r_status already holds the previous op's flags when this op advances.
  always_comb begin
    w_pass = 1'b0;
    case (r_iss_cond)
      4'h0:    w_pass = w_z;
      4'h1:    w_pass = !w_z;
      4'h2:    w_pass = w_c;
      4'h3:    w_pass = !w_c;
      4'h4:    w_pass = w_n;
      4'h5:    w_pass = !w_n;
      4'h6:    w_pass = w_v;
      4'h7:    w_pass = !w_v;
      4'h8:    w_pass = w_c && !w_z;
      4'h9:    w_pass = !w_c || w_z;
      4'hA:    w_pass = (w_n == w_v);
      4'hB:    w_pass = (w_n != w_v);
      4'hC:    w_pass = !w_z && (w_n == w_v);
      4'hD:    w_pass = w_z || (w_n != w_v);
      4'hE:    w_pass = 1'b1;
      default: w_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        r_iss_cond <= '0;
    else if (w_accept) r_iss_cond <= in_cond;
  end
`else
  logic w_unused_cond;

  assign w_unused_cond = ^in_cond;
  assign w_pass        = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_iss_v    <= 1'b0;
      r_iss_a    <= '0;
      r_iss_b    <= '0;
      r_iss_op   <= '0;
      r_iss_setf <= 1'b0;
    end else if (w_accept) begin
      r_iss_v    <= 1'b1;
      r_iss_a    <= in_srca;
      r_iss_b    <= in_srcb;
      r_iss_op   <= in_op;
      r_iss_setf <= in_setf;
    end else if (w_adv) begin
      r_iss_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_v      <= 1'b0;
      r_out_result <= '0;
      r_out_flags  <= '0;
      r_out_exec   <= 1'b0;
    end else if (w_adv) begin
      r_out_v      <= 1'b1;
      r_out_result <= alu_result;
      r_out_flags  <= alu_flags;
      r_out_exec   <= w_pass;
    end else if (out_ready) begin
      r_out_v      <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                           r_status <= '0;
    else if (w_adv && w_pass && r_iss_setf) r_status <= alu_flags;
  end

  assign alu_srca   = r_iss_a;
  assign alu_srcb   = r_iss_b;
  assign alu_ctrl   = r_iss_op;
  assign out_valid  = r_out_v;
  assign out_result = r_out_result;
  assign out_flags  = r_out_flags;
  assign out_exec   = r_out_exec;
  assign status     = r_status;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized and directed bench for alu_exec_stage with a stub ALU and an in-order reference model.
// Honours ALU_COND_EXEC_EN the same way the design does.
module tb_alu_exec_stage;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_srca, in_srcb;
  logic [1:0]   in_op;
  logic [3:0]   in_cond;
  logic         in_setf;
  logic [W-1:0] alu_srca, alu_srcb;
  logic [1:0]   alu_ctrl;
  logic [W-1:0] alu_result;
  logic [3:0]   alu_flags;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;
  logic         out_exec;
  logic [3:0]   status;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [3:0] res;
    logic [3:0] flg;
    logic       exec;
    logic [3:0] st;
  } exp_t;

  exp_t       expq[$];
  logic [3:0] m_status = '0;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_srca(in_srca), .in_srcb(in_srcb), .in_op(in_op),
    .in_cond(in_cond), .in_setf(in_setf),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .out_exec(out_exec), .status(status)
  );

  // Returns {C,V,N,Z, result}; SUB carry is a borrow (set when a < b).
  function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int ua, ub, sa, sb, u, s;
    logic [3:0] r;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = a[3] ? ua - 16 : ua;
    sb = b[3] ? ub - 16 : ub;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0:    r = a & b;
      2'd1:    r = a | b;
      2'd2: begin
        u = ua + ub; s = sa + sb;
        r = 4'(u % 16); c = (u > 15); v = (s > 7) || (s < -8);
      end
      default: begin
        u = ua - ub; s = sa - sb;
        r = 4'((u + 16) % 16); c = (ua < ub); v = (s > 7) || (s < -8);
      end
    endcase
    return {c, v, r[3], (r == 4'd0), r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_ref(alu_ctrl, alu_srca, alu_srcb);

  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] st);
    logic c, v, n, z, base;
    {c, v, n, z} = st;
    case (cc >> 1)
      0: base = z;
      1: base = c;
      2: base = n;
      3: base = v;
      4: base = c && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
`ifdef ALU_COND_EXEC_EN
    return cc[0] ? !base : base;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [3:0] a, b, input logic [1:0] op, input logic [3:0] cc, input logic sf);
    exp_t e;
    logic [7:0] fr;
    fr = alu_ref(op, a, b);
    e.exec = cond_ok(cc, m_status);
    e.res  = fr[3:0];
    e.flg  = fr[7:4];
    if (e.exec && sf) m_status = e.flg;
    e.st = m_status;
    expq.push_back(e);
  endtask

  // One clock: drive at negedge, check settled outputs, book the handshakes of the coming edge.
  task automatic cycle(input logic v, input logic [3:0] a, b, input logic [1:0] op,
                       input logic [3:0] cc, input logic sf, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_srca = a; in_srcb = b; in_op = op; in_cond = cc; in_setf = sf;
    out_ready = ordy;
    #1;
    if (out_valid) begin
      if (expq.size() == 0) begin
        check_eq("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = expq[0];
        check_eq("out_result", 32'(out_result), 32'(e.res));
        check_eq("out_flags",  32'(out_flags),  32'(e.flg));
        check_eq("out_exec",   32'(out_exec),   32'(e.exec));
        check_eq("status",     32'(status),     32'(e.st));
        if (ordy) void'(expq.pop_front());
      end
    end
    if (v && in_ready) model_accept(a, b, op, cc, sf);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 4'd0, 4'd0, 2'd0, 4'hE, 1'b0, ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && expq.size() > 0; i++) idle(1'b1);
    check_eq("drain_left", 32'(expq.size()), 32'd0);
    idle(1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_srca = '0; in_srcb = '0; in_op = '0;
    in_cond = '0; in_setf = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_status", 32'(status), 32'd0);
    check_eq("rst_alu_srca", 32'(alu_srca), 32'd0);
    check_eq("rst_out_result", 32'(out_result), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // ADD 7+1: latency and flags
    cycle(1'b1, 4'h7, 4'h1, 2'd2, 4'hE, 1'b1, 1'b1);
    idle(1'b1);
    check_eq("lat_early", 32'(out_valid), 32'd0);
    idle(1'b1);
    check_eq("lat_valid", 32'(out_valid), 32'd1);
    check_eq("add_result", 32'(out_result), 32'h8);
    check_eq("add_flags", 32'(out_flags), 32'h6);
    check_eq("add_status", 32'(status), 32'h6);
    drain();

    // Back-to-back SUBs, second reads the first's fresh Z
    cycle(1'b1, 4'h5, 4'h5, 2'd3, 4'hE, 1'b1, 1'b1);
    cycle(1'b1, 4'h3, 4'h5, 2'd3, 4'h0, 1'b1, 1'b1);
    drain();
    check_eq("sub_status", 32'(status), 32'hA);

    // Condition checks starting from status Z=1
    cycle(1'b1, 4'h5, 4'h5, 2'd3, 4'hE, 1'b1, 1'b1);
    drain();
    check_eq("z_status", 32'(status), 32'h1);
    cycle(1'b1, 4'hF, 4'h3, 2'd0, 4'h1, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
`ifdef ALU_COND_EXEC_EN
    check_eq("ne_exec", 32'(out_exec), 32'd0);
    check_eq("ne_status", 32'(status), 32'h1);
`else
    check_eq("ne_exec", 32'(out_exec), 32'd1);
    check_eq("ne_status", 32'(status), 32'h0);
`endif
    drain();
    cycle(1'b1, 4'h1, 4'h2, 2'd1, 4'hF, 1'b0, 1'b1);
    cycle(1'b1, 4'h1, 4'h2, 2'd1, 4'hE, 1'b0, 1'b1);
    drain();

    // Backpressure: two accepted, third refused until release
    cycle(1'b1, 4'h1, 4'h1, 2'd2, 4'hE, 1'b1, 1'b0);
    cycle(1'b1, 4'h2, 4'h2, 2'd2, 4'hE, 1'b1, 1'b0);
    cycle(1'b1, 4'h9, 4'h4, 2'd3, 4'hE, 1'b1, 1'b0);
    check_eq("bp_full", 32'(in_ready), 32'd0);
    cycle(1'b1, 4'h9, 4'h4, 2'd3, 4'hE, 1'b1, 1'b0);
    check_eq("bp_hold", 32'(in_ready), 32'd0);
    cycle(1'b1, 4'h9, 4'h4, 2'd3, 4'hE, 1'b1, 1'b1);
    check_eq("bp_rel_ready", 32'(in_ready), 32'd1);
    idle(1'b1);
    check_eq("bp_second", 32'(out_valid), 32'd1);
    idle(1'b1);
    check_eq("bp_third", 32'(out_valid), 32'd1);
    check_eq("bp_left", 32'(expq.size()), 32'd0);
    idle(1'b1);
    check_eq("bp_empty", 32'(out_valid), 32'd0);

    // Reset with two ops in flight
    cycle(1'b1, 4'h6, 4'h3, 2'd2, 4'hE, 1'b1, 1'b0);
    cycle(1'b1, 4'h6, 4'h7, 2'd3, 4'hE, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    #1 check_eq("rst_mid_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mid_status", 32'(status), 32'd0);
    check_eq("rst_mid_in_ready", 32'(in_ready), 32'd1);
    expq.delete();
    m_status = '0;
    repeat (4) idle(1'b1);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 2'($urandom),
            4'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
